// File: rtl/arbtst_client_n.sv
// arbtst_client_n: arbiter-test client for a shared-resource stress bench.
//
// Accepts an operand pair (din_valid/din_ready), requests the shared resource
// (req/gnt), streams the operands to it (sub_valid/aout/bout), samples the
// result (yin) LAT cycles later, optionally re-runs PASSES times with the
// result fed back as operand A, then returns the result (dout_valid/dout_ready).
//
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   din_valid    operand pair offered          din_ready   client accepts operands
//   ain, bin     operands A and B
//   req          request to arbiter            gnt         grant from arbiter
//   sub_valid    operand strobe to resource    aout, bout  operands to resource
//   yin          result from resource
//   dout_valid   result available              dout_ready  consumer accepts result
//   yout         result
//   timeout_err  one-cycle pulse on grant timeout
//
// All outputs are decoded from registered state only.
module arbtst_client_n #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned PASSES  = 1,
   parameter int unsigned LAT     = 1,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   output logic             req,
   input  logic             gnt,
   output logic             sub_valid,
   output logic [WIDTH-1:0] aout,
   output logic [WIDTH-1:0] bout,
   input  logic [WIDTH-1:0] yin,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [WIDTH-1:0] yout,
   output logic             timeout_err
);

   localparam int unsigned PW = $clog2(PASSES) + 1;
   localparam int unsigned WW = $clog2(TIMEOUT) + 1;
   localparam int unsigned LW = $clog2(LAT) + 1;

   localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
   // Only meaningful when LAT > 1; WAIT is never entered otherwise.
   localparam logic [LW-1:0] LAT_LAST  = (LAT > 1) ? LW'(LAT - 2) : '0;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StReq     = 3'd1,
      StBackoff = 3'd2,
      StWrite   = 3'd3,
      StWait    = 3'd4,
      StRead    = 3'd5,
      StOut     = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  areg_q, areg_d;
   logic [WIDTH-1:0]  breg_q, breg_d;
   logic [PW-1:0]     pass_q, pass_d;
   logic [WW-1:0]     wait_q, wait_d;
   logic [LW-1:0]     lat_q, lat_d;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         areg_q  <= '0;
         breg_q  <= '0;
         pass_q  <= '0;
         wait_q  <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         areg_q  <= areg_d;
         breg_q  <= breg_d;
         pass_q  <= pass_d;
         wait_q  <= wait_d;
         lat_q   <= lat_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      areg_d  = areg_q;
      breg_d  = breg_q;
      pass_d  = pass_q;
      wait_d  = wait_q;
      lat_d   = lat_q;
      case (state_q)
         StIdle: begin
            if (din_valid) begin
               areg_d  = ain;
               breg_d  = bin;
               pass_d  = '0;
               wait_d  = '0;
               state_d = StReq;
            end
         end
         StReq: begin
            // A grant in the final wait cycle beats the timeout.
            if (gnt) begin
               state_d = StWrite;
            end else if (wait_q == WAIT_LAST) begin
               state_d = StBackoff;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StBackoff: begin
            wait_d  = '0;
            state_d = StReq;
         end
         StWrite: begin
            lat_d   = '0;
            state_d = (LAT > 1) ? StWait : StRead;
         end
         StWait: begin
            if (lat_q == LAT_LAST) begin
               state_d = StRead;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         StRead: begin
            // Result becomes operand A of the next pass; grant is held throughout.
            areg_d = yin;
            if (pass_q == PASS_LAST) begin
               state_d = StOut;
            end else begin
               pass_d  = pass_q + 1'b1;
               state_d = StWrite;
            end
         end
         StOut: begin
            if (dout_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode
   always_comb begin
      din_ready   = 1'b0;
      req         = 1'b0;
      sub_valid   = 1'b0;
      aout        = '0;
      bout        = '0;
      dout_valid  = 1'b0;
      yout        = '0;
      timeout_err = 1'b0;
      case (state_q)
         StIdle:    din_ready = 1'b1;
         StReq:     req = 1'b1;
         StBackoff: timeout_err = 1'b1;
         StWrite: begin
            req       = 1'b1;
            sub_valid = 1'b1;
            aout      = areg_q;
            bout      = breg_q;
         end
         StWait:    req = 1'b1;
         StRead:    req = 1'b1;
         StOut: begin
            dout_valid = 1'b1;
            yout       = areg_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_arbtst_client_n.sv
module tb_arbtst_client_n;

   logic clk;
   logic reset;

   // Instance A: PASSES=1, LAT=1, TIMEOUT=15
   logic       din_valid_a, din_ready_a, req_a, gnt_a, sub_valid_a;
   logic       dout_valid_a, dout_ready_a, timeout_err_a;
   logic [3:0] ain_a, bin_a, aout_a, bout_a, yin_a, yout_a;

   // Instance B: PASSES=3, LAT=2, TIMEOUT=4
   logic       din_valid_b, din_ready_b, req_b, gnt_b, sub_valid_b;
   logic       dout_valid_b, dout_ready_b, timeout_err_b;
   logic [3:0] ain_b, bin_b, aout_b, bout_b, yin_b, yout_b;

   int checks   = 0;
   int failures = 0;

   arbtst_client_n #(.WIDTH(4), .PASSES(1), .LAT(1), .TIMEOUT(15)) dut_a (
      .clk(clk), .reset(reset),
      .din_valid(din_valid_a), .din_ready(din_ready_a), .ain(ain_a), .bin(bin_a),
      .req(req_a), .gnt(gnt_a), .sub_valid(sub_valid_a), .aout(aout_a), .bout(bout_a),
      .yin(yin_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready_a), .yout(yout_a),
      .timeout_err(timeout_err_a)
   );

   arbtst_client_n #(.WIDTH(4), .PASSES(3), .LAT(2), .TIMEOUT(4)) dut_b (
      .clk(clk), .reset(reset),
      .din_valid(din_valid_b), .din_ready(din_ready_b), .ain(ain_b), .bin(bin_b),
      .req(req_b), .gnt(gnt_b), .sub_valid(sub_valid_b), .aout(aout_b), .bout(bout_b),
      .yin(yin_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b), .yout(yout_b),
      .timeout_err(timeout_err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared-resource models: y = a + b mod 16, registered on the strobe, held.
   always @(posedge clk) begin
      if (sub_valid_a) yin_a <= aout_a + bout_a;
      if (sub_valid_b) yin_b <= aout_b + bout_b;
   end

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] y;
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs dut_a from cycle `start` until dout_valid (bounded); reports the OUT cycle,
   // strobe count, last strobed A, and any protocol violation.
   task automatic run_a(input int start, input logic [3:0] b, output int cyc, output int ns,
                        output logic [3:0] sa, output logic bad);
      cyc = start; ns = 0; sa = '0; bad = 1'b0;
      while (!dout_valid_a && cyc < 100) begin
         if (sub_valid_a) begin
            ns++;
            sa = aout_a;
            if (bout_a !== b) bad = 1'b1;
         end else if (aout_a !== 4'd0 || bout_a !== 4'd0) begin
            bad = 1'b1;
         end
         if (yout_a !== 4'd0 || timeout_err_a) bad = 1'b1;
         step();
         cyc++;
      end
   endtask

   // Same for dut_b; strobes collects the A operands in order, gap counts req-low
   // cycles after req was first seen.
   task automatic run_b(input int start, input logic [3:0] b, output int cyc, output int ns,
                        output logic [11:0] strobes, output int gap, output logic bad);
      logic seen;
      cyc = start; ns = 0; strobes = '0; gap = 0; bad = 1'b0; seen = 1'b0;
      while (!dout_valid_b && cyc < 200) begin
         if (sub_valid_b) begin
            ns++;
            strobes = {strobes[7:0], aout_b};
            if (bout_b !== b) bad = 1'b1;
         end else if (aout_b !== 4'd0 || bout_b !== 4'd0) begin
            bad = 1'b1;
         end
         if (yout_b !== 4'd0) bad = 1'b1;
         if (req_b) seen = 1'b1;
         else if (seen) gap++;
         step();
         cyc++;
      end
   endtask

   task automatic release_b();
      dout_ready_b = 1'b1;
      step();
      dout_ready_b = 1'b0;
   endtask

   initial begin
      int cyc, ns, gap;
      logic [3:0] sa;
      logic [11:0] strobes;
      logic bad, flag;
      logic [9:0] req_pat, terr_pat;

      vecs[0] = '{a: 4'd3,  b: 4'd5, y: 4'd8};
      vecs[1] = '{a: 4'd15, b: 4'd1, y: 4'd0};
      vecs[2] = '{a: 4'd7,  b: 4'd9, y: 4'd0};
      vecs[3] = '{a: 4'd10, b: 4'd10, y: 4'd4};
      vecs[4] = '{a: 4'd6,  b: 4'd4, y: 4'hA};

      reset = 1'b0;
      din_valid_a = 0; ain_a = 0; bin_a = 0; gnt_a = 1; dout_ready_a = 0; yin_a = 0;
      din_valid_b = 0; ain_b = 0; bin_b = 0; gnt_b = 1; dout_ready_b = 0; yin_b = 0;
      step();
      step();

      // Reset state
      chk("rst_a_ctrl", {din_ready_a, req_a, sub_valid_a, dout_valid_a, timeout_err_a}, 5'b10000);
      chk("rst_a_data", {aout_a, bout_a, yout_a}, 12'h000);
      chk("rst_b_ctrl", {din_ready_b, req_b, sub_valid_b, dout_valid_b, timeout_err_b}, 5'b10000);
      chk("rst_b_data", {aout_b, bout_b, yout_b}, 12'h000);
      reset = 1'b1;
      step();

      // Minimum-latency table on dut_a (gnt tied high)
      for (int i = 0; i < 5; i++) begin
         chk("tbl_din_ready", din_ready_a, 1'b1);
         din_valid_a = 1'b1; ain_a = vecs[i].a; bin_a = vecs[i].b;
         step();
         din_valid_a = 1'b0;
         run_a(1, vecs[i].b, cyc, ns, sa, bad);
         chk("tbl_latency", cyc, 4);
         chk("tbl_strobes", ns, 1);
         chk("tbl_aout", sa, vecs[i].a);
         chk("tbl_protocol", bad, 1'b0);
         chk("tbl_yout", yout_a, vecs[i].y);
         dout_ready_a = 1'b1;
         step();
         dout_ready_a = 1'b0;
      end

      // Delayed grant on dut_a: gnt 6 cycles after req rises, no timeout
      gnt_a = 1'b0;
      din_valid_a = 1'b1; ain_a = 4'd6; bin_a = 4'd7;
      step();
      din_valid_a = 1'b0;
      flag = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (!req_a || timeout_err_a || sub_valid_a) flag = 1'b1;
         step();
      end
      if (!req_a) flag = 1'b1;
      gnt_a = 1'b1;
      step();
      chk("dly_wait_phase", flag, 1'b0);
      chk("dly_write_next", sub_valid_a, 1'b1);
      run_a(8, 4'd7, cyc, ns, sa, bad);
      chk("dly_latency", cyc, 10);
      chk("dly_protocol", bad, 1'b0);
      chk("dly_yout", yout_a, 4'hD);
      dout_ready_a = 1'b1;
      step();
      dout_ready_a = 1'b0;

      // Output back-pressure on dut_a
      din_valid_a = 1'b1; ain_a = 4'd2; bin_a = 4'd3;
      step();
      din_valid_a = 1'b0;
      run_a(1, 4'd3, cyc, ns, sa, bad);
      chk("bp_first_yout", yout_a, 4'd5);
      din_valid_a = 1'b1; ain_a = 4'd9; bin_a = 4'd4;
      flag = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (!dout_valid_a || yout_a !== 4'd5 || din_ready_a || req_a) flag = 1'b1;
         step();
      end
      chk("bp_hold_stable", flag, 1'b0);
      dout_ready_a = 1'b1;
      step();
      dout_ready_a = 1'b0;
      chk("bp_idle_ctrl", {din_ready_a, dout_valid_a}, 2'b10);
      step();
      din_valid_a = 1'b0;
      run_a(1, 4'd4, cyc, ns, sa, bad);
      chk("bp_second_latency", cyc, 4);
      chk("bp_second_aout", sa, 4'd9);
      chk("bp_second_yout", yout_a, 4'hD);
      dout_ready_a = 1'b1;
      step();
      dout_ready_a = 1'b0;

      // Three passes on dut_b, grant held
      din_valid_b = 1'b1; ain_b = 4'd2; bin_b = 4'd5;
      step();
      din_valid_b = 1'b0;
      run_b(1, 4'd5, cyc, ns, strobes, gap, bad);
      chk("mp_latency", cyc, 11);
      chk("mp_strobes", ns, 3);
      chk("mp_aout_seq", strobes, 12'h27C);
      chk("mp_req_gap", gap, 0);
      chk("mp_protocol", bad, 1'b0);
      chk("mp_yout", yout_b, 4'd1);
      release_b();

      // Grant in the last allowed wait cycle wins over timeout
      gnt_b = 1'b0;
      din_valid_b = 1'b1; ain_b = 4'd4; bin_b = 4'd3;
      step();
      din_valid_b = 1'b0;
      flag = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (!req_b || timeout_err_b) flag = 1'b1;
         step();
      end
      gnt_b = 1'b1;
      step();
      chk("edge_wait_phase", flag, 1'b0);
      chk("edge_write", {sub_valid_b, timeout_err_b}, 2'b10);
      run_b(5, 4'd3, cyc, ns, strobes, gap, bad);
      chk("edge_latency", cyc, 14);
      chk("edge_aout_seq", strobes, 12'h47A);
      chk("edge_yout", yout_b, 4'hD);
      release_b();

      // Timeout and backoff on dut_b, then grant
      gnt_b = 1'b0;
      din_valid_b = 1'b1; ain_b = 4'd1; bin_b = 4'd2;
      step();
      din_valid_b = 1'b0;
      req_pat = '0; terr_pat = '0;
      for (int k = 1; k <= 10; k++) begin
         req_pat  = {req_pat[8:0], req_b};
         terr_pat = {terr_pat[8:0], timeout_err_b};
         step();
      end
      chk("to_req_pattern", req_pat, 10'b1111011110);
      chk("to_terr_pattern", terr_pat, 10'b0000100001);
      gnt_b = 1'b1;
      run_b(11, 4'd2, cyc, ns, strobes, gap, bad);
      chk("to_latency", cyc, 21);
      chk("to_aout_seq", strobes, 12'h135);
      chk("to_req_gap", gap, 0);
      chk("to_yout", yout_b, 4'd7);
      release_b();

      // Reset asserted during WAIT on dut_b
      din_valid_b = 1'b1; ain_b = 4'd1; bin_b = 4'd1;
      step();
      din_valid_b = 1'b0;
      step();
      step();
      chk("rmid_before", {req_b, sub_valid_b}, 2'b10);
      #2 reset = 1'b0;
      #1;
      chk("rmid_async_drop", {req_b, sub_valid_b, dout_valid_b, din_ready_b}, 4'b0001);
      step();
      #3 reset = 1'b1;
      step();
      chk("rmid_after", {din_ready_b, req_b, dout_valid_b, yout_b}, 7'b1000000);
      din_valid_b = 1'b1; ain_b = 4'd3; bin_b = 4'd2;
      step();
      din_valid_b = 1'b0;
      run_b(1, 4'd2, cyc, ns, strobes, gap, bad);
      chk("rmid_latency", cyc, 11);
      chk("rmid_aout_seq", strobes, 12'h357);
      chk("rmid_yout", yout_b, 4'd9);
      release_b();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
